// File: rtl/pulpemu_gpio_pkg.sv
// Shared GPIO bit map, boot sequencer state type and reset word for the
// zynq2pulp / pulp2zynq GPIO pair of the PULP emulation platform.
package pulpemu_gpio_pkg;

  localparam int unsigned Z2P_RSTN           = 31;
  localparam int unsigned Z2P_CLKEN          = 30;
  localparam int unsigned Z2P_FAULTEN        = 29;
  localparam int unsigned Z2P_SAFEN_SPIS     = 8;
  localparam int unsigned Z2P_SAFEN_SPIM     = 7;
  localparam int unsigned Z2P_SAFEN_UART     = 6;
  localparam int unsigned Z2P_TRACE_FLUSHED  = 4;
  localparam int unsigned Z2P_STDOUT_FLUSHED = 3;
  localparam int unsigned Z2P_MODE           = 2;
  localparam int unsigned Z2P_FETCHEN        = 0;

  localparam int unsigned P2Z_EOC         = 0;
  localparam int unsigned P2Z_RET_LSB     = 1;
  localparam int unsigned P2Z_RET_MSB     = 2;
  localparam int unsigned P2Z_STDOUT_WAIT = 3;
  localparam int unsigned P2Z_TRACE_WAIT  = 4;

  localparam logic [31:0] Z2P_RESET = 32'h000001C0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_CLKON,
    ST_BOOT,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } boot_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulpemu_gpio_flush_hs.sv
// One host-side buffer flush handshake: a rising WAIT raises a drain request,
// the host's drain-done retires it and FLUSHED is held until WAIT falls.
module pulpemu_gpio_flush_hs (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic wait_i,
  input  logic drain_done_i,
  output logic drain_req_o,
  output logic flushed_o,
  output logic pending_o
);

  logic wait_q;
  logic req_q, req_d;
  logic flushed_q, flushed_d;
  logic rise;

  assign rise = wait_i & ~wait_q;

  always_comb begin
    req_d     = req_q;
    flushed_d = flushed_q;
    if (clr_i) begin
      req_d     = 1'b0;
      flushed_d = 1'b0;
    end else if (en_i) begin
      if (flushed_q && !wait_i) flushed_d = 1'b0;
      if (req_q && drain_done_i) begin
        req_d     = 1'b0;
        flushed_d = 1'b1;
      end else if (rise) begin
        req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= 1'b0;
      req_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      wait_q    <= wait_i;
      req_q     <= req_d;
      flushed_q <= flushed_d;
    end
  end

  assign drain_req_o = req_q;
  assign flushed_o   = flushed_q;
  // A request being raised this cycle already blocks end-of-computation.
  assign pending_o   = req_q | (en_i & ~clr_i & rise);

endmodule

// File: rtl/pulpemu_gpio_boot_ctrl.sv
// Host-side PULP boot sequencer: drives reset/clock/fetch-enable over the
// zynq2pulp GPIO word and watches EOC, return value and flush requests.
module pulpemu_gpio_boot_ctrl
  import pulpemu_gpio_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned CLK_CYCLES     = 8,
  parameter int unsigned BOOT_CYCLES    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        mode_fmc_zynqn_i,
  input  logic        fault_en_i,
  input  logic [2:0]  safen_cfg_i,
  input  logic [31:0] pulp2zynq_gpio_i,
  output logic [31:0] zynq2pulp_gpio_o,
  input  logic        stdout_drain_done_i,
  input  logic        trace_drain_done_i,
  output logic        stdout_drain_req_o,
  output logic        trace_drain_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [1:0]  ret_val_o
);

  localparam int unsigned CMAX = (RST_CYCLES > CLK_CYCLES)
                               ? ((RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES)
                               : ((CLK_CYCLES > BOOT_CYCLES) ? CLK_CYCLES : BOOT_CYCLES);
  localparam int unsigned CW   = cnt_width(CMAX);
  localparam int unsigned TW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  boot_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [1:0]      ret_q, ret_d;
  logic [31:0]     sync1_q, sync2_q;
  logic            mode_q, fault_q;
  logic [2:0]      safen_q;
  logic            hs_en;
  logic            so_flushed, tr_flushed, so_pending, tr_pending;
  logic            unused_p2z;

  assign unused_p2z = ^sync2_q[31:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      mode_q  <= 1'b0;
      fault_q <= 1'b0;
      safen_q <= '1;
    end else begin
      sync1_q <= pulp2zynq_gpio_i;
      sync2_q <= sync1_q;
      mode_q  <= mode_fmc_zynqn_i;
      fault_q <= fault_en_i;
      safen_q <= safen_cfg_i;
    end
  end

  assign hs_en = (state_q == ST_RUN) || (state_q == ST_DONE);

  pulpemu_gpio_flush_hs u_stdout_hs (
    .clk          (clk),
    .rst          (rst),
    .en_i         (hs_en),
    .clr_i        (abort_i),
    .wait_i       (sync2_q[P2Z_STDOUT_WAIT]),
    .drain_done_i (stdout_drain_done_i),
    .drain_req_o  (stdout_drain_req_o),
    .flushed_o    (so_flushed),
    .pending_o    (so_pending)
  );

  pulpemu_gpio_flush_hs u_trace_hs (
    .clk          (clk),
    .rst          (rst),
    .en_i         (hs_en),
    .clr_i        (abort_i),
    .wait_i       (sync2_q[P2Z_TRACE_WAIT]),
    .drain_done_i (trace_drain_done_i),
    .drain_req_o  (trace_drain_req_o),
    .flushed_o    (tr_flushed),
    .pending_o    (tr_pending)
  );

  // Timeout compares the post-increment count so RUN lasts exactly TIMEOUT_CYCLES.
  assign tcnt_inc = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + TW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    ret_d   = ret_q;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
      ST_RESET: if (cnt_q == CW'(RST_CYCLES - 1)) begin
        state_d = ST_CLKON;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      ST_CLKON: if (cnt_q == CW'(CLK_CYCLES - 1)) begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      ST_BOOT: if (cnt_q == CW'(BOOT_CYCLES - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        tcnt_d  = '0;
      end else cnt_d = cnt_q + CW'(1);
      ST_RUN: begin
        tcnt_d = tcnt_inc;
        if (sync2_q[P2Z_EOC] && !so_pending && !tr_pending) begin
          state_d = ST_DONE;
          ret_d   = sync2_q[P2Z_RET_MSB:P2Z_RET_LSB];
        end else if (TIMEOUT_CYCLES != 0 && tcnt_inc == TMAX) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE, ST_TIMEOUT: if (start_i) begin
        state_d = ST_RESET;
        cnt_d   = '0;
        ret_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ret_d   = ret_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    zynq2pulp_gpio_o                     = '0;
    zynq2pulp_gpio_o[Z2P_RSTN]           = (state_q == ST_BOOT) || (state_q == ST_RUN) ||
                                           (state_q == ST_DONE);
    zynq2pulp_gpio_o[Z2P_CLKEN]          = (state_q == ST_CLKON) || (state_q == ST_BOOT) ||
                                           (state_q == ST_RUN) || (state_q == ST_DONE);
    zynq2pulp_gpio_o[Z2P_FAULTEN]        = fault_q;
    zynq2pulp_gpio_o[Z2P_SAFEN_SPIS]     = safen_q[2];
    zynq2pulp_gpio_o[Z2P_SAFEN_SPIM]     = safen_q[1];
    zynq2pulp_gpio_o[Z2P_SAFEN_UART]     = safen_q[0];
    zynq2pulp_gpio_o[Z2P_TRACE_FLUSHED]  = tr_flushed;
    zynq2pulp_gpio_o[Z2P_STDOUT_FLUSHED] = so_flushed;
    zynq2pulp_gpio_o[Z2P_MODE]           = mode_q;
    zynq2pulp_gpio_o[Z2P_FETCHEN]        = (state_q == ST_RUN);
  end

  assign busy_o    = (state_q == ST_RESET) || (state_q == ST_CLKON) ||
                     (state_q == ST_BOOT) || (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);
  assign timeout_o = (state_q == ST_TIMEOUT);
  assign ret_val_o = ret_q;

endmodule
